// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle: IF pushes {pc, inst}, ID pops the head.
// The queue takes the slave side; the surrounding pipeline (or a bench) takes master.
interface if_id_queue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_inst;
    logic            in_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;
    logic            out_ready;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular buffer of {pc, inst} with flush, global
// freeze (rdy) and a bubble instruction presented whenever the queue is empty.
module if_id_queue #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH       = 4,
    parameter logic [XLEN-1:0] BUBBLE_INST = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush_i,
    if_id_queue_if.slave               q,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("if_id_queue: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            push;
    logic            pop;

    always_comb begin
        q.in_ready  = (count < FULL);
        q.out_valid = (count != '0);
        push        = q.in_valid  && q.in_ready  && rdy && !flush_i;
        pop         = q.out_valid && q.out_ready && rdy && !flush_i;
        // Storage is never reset, so an empty queue must mask the stale head.
        q.out_pc    = q.out_valid ? pc_mem[rd_ptr]   : '0;
        q.out_inst  = q.out_valid ? inst_mem[rd_ptr] : BUBBLE_INST;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= q.in_pc;
            inst_mem[wr_ptr] <= q.in_inst;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (rdy) begin
            if (flush_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule
